// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and helpers for the 8N1 UART transmitter:
//                baud-select encodings, frame length, divisor and frame-bit
//                lookup functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Run-time baud-select encodings (5..7 fall back to 9600)
  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  // start + 8 data + stop
  localparam int unsigned UART_FRAME_BITS = 10;

  // Clocks per bit for a given select, integer-truncated
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input logic [2:0]  sel);
    int unsigned div;
    case (sel)
      BAUD_19200:  div = clk_freq / 19200;
      BAUD_38400:  div = clk_freq / 38400;
      BAUD_57600:  div = clk_freq / 57600;
      BAUD_115200: div = clk_freq / 115200;
      default:     div = clk_freq / 9600;
    endcase
    return div;
  endfunction

  // Line level for bit slot idx: 0 = start, 1..8 = data LSB first, 9+ = stop
  function automatic logic frame_bit(input logic [7:0] data,
                                     input logic [3:0] idx);
    logic       bit_val;
    logic [2:0] data_idx;
    data_idx = 3'(idx - 4'd1);
    if (idx == 4'd0) begin
      bit_val = 1'b0;
    end else if (idx <= 4'd8) begin
      bit_val = data[data_idx];
    end else begin
      bit_val = 1'b1;
    end
    return bit_val;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period divider. Counts 0..DIV-1 while enabled and emits
//                a one-cycle bit_tick in the last clock of each bit period.
//                The counter is held at zero while disabled so every frame
//                starts with a full-length first bit.
//  Revision    : 1.0 - initial release
// ============================================================================
import uart_pkg::*;

module uart_baud_gen #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [2:0] baud_sel,
  input  logic       enable,
  output logic       bit_tick
);

  // Wide enough for the slowest (largest) divisor
  localparam int unsigned DIV_W = $clog2(CLK_FREQ / 9600 + 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] div_m1;

  assign div_m1   = DIV_W'(baud_div(CLK_FREQ, baud_sel) - 1);
  assign bit_tick = enable && (cnt_q == div_m1);

  // Next divider count: clear when idle or on wrap, else increment
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_byte_tx_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_byte_tx_core
//  Description : 8N1 UART byte transmitter. A send_en strobe while idle
//                latches data_byte and baud_set and shifts out start, eight
//                data bits LSB first and stop. Tx_Done pulses for one cycle
//                as the stop bit completes; uart_state flags a busy frame.
//  Revision    : 1.0 - initial release
// ============================================================================
import uart_pkg::*;

module uart_byte_tx_core #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] data_byte,
  input  logic       send_en,
  input  logic [2:0] baud_set,
  output logic       Rs232_Tx,
  output logic       Tx_Done,
  output logic       uart_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [3:0] LAST_IDX = 4'(UART_FRAME_BITS - 1);

  logic [0:0] state_q, state_d;
  logic [7:0] data_q,  data_d;
  logic [2:0] baud_q,  baud_d;
  logic [3:0] idx_q,   idx_d;
  logic       tx_q,    tx_d;
  logic       done_q,  done_d;

  logic       bit_tick;
  logic       accept;
  logic       last_tick;

  assign accept    = (state_q == ST_IDLE) && send_en;
  assign last_tick = (state_q == ST_SEND) && bit_tick && (idx_q == LAST_IDX);

  // Bit-period divider runs only while a frame is in flight
  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_baud_gen (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .baud_sel (baud_q),
    .enable   (state_q == ST_SEND),
    .bit_tick (bit_tick)
  );

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start on an accepted strobe, return after the stop bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_SEND;
      ST_SEND: if (last_tick) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: latch on accept, step the bit index on each tick
  always_comb begin
    data_d = data_q;
    baud_d = baud_q;
    idx_d  = idx_q;
    tx_d   = tx_q;
    done_d = 1'b0;
    if (accept) begin
      data_d = data_byte;
      baud_d = baud_set;
      idx_d  = 4'd0;
      tx_d   = 1'b0;
    end else if ((state_q == ST_SEND) && bit_tick) begin
      if (last_tick) begin
        idx_d  = 4'd0;
        tx_d   = 1'b1;
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + 4'd1;
        tx_d  = frame_bit(data_q, idx_q + 4'd1);
      end
    end
  end

  // Datapath and output registers; the line idles high
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_q <= 8'h00;
      baud_q <= 3'd0;
      idx_q  <= 4'd0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      baud_q <= baud_d;
      idx_q  <= idx_d;
      tx_q   <= tx_d;
      done_q <= done_d;
    end
  end

  assign Rs232_Tx   = tx_q;
  assign Tx_Done    = done_q;
  assign uart_state = state_q[0];

endmodule : uart_byte_tx_core
`default_nettype wire

// File: tb/tb_uart_byte_tx_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_byte_tx_core
//  Description : Self-checking bench for uart_byte_tx_core at 50 MHz using a
//                table of frames with hand-computed line patterns plus a
//                hand-written asynchronous-reset abort sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_byte_tx_core;

  localparam int POKE_NONE   = 0;
  localparam int POKE_CHANGE = 1;
  localparam int POKE_SEND   = 2;

  typedef struct {
    logic [7:0] data;
    logic [2:0] baud;
    int         div;
    logic [9:0] bits;      // expected line level per slot, [0]=start
    int         poke_cyc;
    int         poke_kind;
    bit         chain;     // raise send_en for the next entry in the Tx_Done cycle
    int         gap;       // idle cycles before the strobe
  } vec_t;

  logic       Clk;
  logic       Rst_n;
  logic [7:0] data_byte;
  logic       send_en;
  logic [2:0] baud_set;
  logic       Rs232_Tx;
  logic       Tx_Done;
  logic       uart_state;

  int   n_checks;
  int   n_errors;
  vec_t vecs [6];

  uart_byte_tx_core #(
    .CLK_FREQ (50_000_000)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .data_byte  (data_byte),
    .send_en    (send_en),
    .baud_set   (baud_set),
    .Rs232_Tx   (Rs232_Tx),
    .Tx_Done    (Tx_Done),
    .uart_state (uart_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Absolute time limit so the run always ends
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached (actual=running, required=finished)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Idle for cnt cycles, checking the line stays quiet
  task automatic idle_check(input string name, input int cnt);
    int bad;
    bad = 0;
    for (int c = 0; c < cnt; c++) begin
      if (Rs232_Tx !== 1'b1 || Tx_Done !== 1'b0 || uart_state !== 1'b0) bad++;
      step();
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  // Transmit table entry i and check every cycle of its frame
  task automatic run_frame(input int i, input bit chained);
    int   bad_line, bad_state, bad_done, first_bad;
    logic first_val;
    int   n;
    if (!chained) begin
      idle_check($sformatf("f%0d_pre_idle", i), vecs[i].gap);
      data_byte = vecs[i].data;
      baud_set  = vecs[i].baud;
      send_en   = 1'b1;
      step();
      send_en   = 1'b0;
    end
    bad_state = 0;
    bad_done  = 0;
    for (int b = 0; b < 10; b++) begin
      bad_line  = 0;
      first_bad = -1;
      first_val = 1'bx;
      for (int c = 0; c < vecs[i].div; c++) begin
        n = b * vecs[i].div + c;
        if (vecs[i].poke_kind == POKE_CHANGE && n == vecs[i].poke_cyc) begin
          baud_set  = (vecs[i].baud == 3'd0) ? 3'd4 : 3'd0;
          data_byte = ~vecs[i].data;
        end
        if (vecs[i].poke_kind == POKE_SEND && n == vecs[i].poke_cyc) begin
          data_byte = 8'hFF;
          send_en   = 1'b1;
        end
        if (vecs[i].poke_kind == POKE_SEND && n == vecs[i].poke_cyc + 1) begin
          send_en   = 1'b0;
        end
        if (Rs232_Tx !== vecs[i].bits[b]) begin
          if (bad_line == 0) begin
            first_bad = c;
            first_val = Rs232_Tx;
          end
          bad_line++;
        end
        if (uart_state !== 1'b1) bad_state++;
        if (Tx_Done !== 1'b0) bad_done++;
        step();
      end
      n_checks++;
      if (bad_line != 0) begin
        n_errors++;
        $display("FAIL f%0d_bit%0d: actual=%b at cycle %0d of slot (%0d bad cycles) required=%b",
                 i, b, first_val, first_bad, bad_line, vecs[i].bits[b]);
      end
    end
    chk($sformatf("f%0d_busy_span", i), 32'(bad_state), 32'd0);
    chk($sformatf("f%0d_no_early_done", i), 32'(bad_done), 32'd0);
    chk($sformatf("f%0d_done_pulse", i), 32'(Tx_Done), 32'd1);
    chk($sformatf("f%0d_idle_at_done", i), 32'(uart_state), 32'd0);
    chk($sformatf("f%0d_line_at_done", i), 32'(Rs232_Tx), 32'd1);
    if (vecs[i].chain) begin
      data_byte = vecs[i+1].data;
      baud_set  = vecs[i+1].baud;
      send_en   = 1'b1;
    end
    step();
    send_en = 1'b0;
    chk($sformatf("f%0d_done_one_cycle", i), 32'(Tx_Done), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    Rst_n     = 1'b0;
    send_en   = 1'b0;
    data_byte = 8'h00;
    baud_set  = 3'd0;

    //            data   baud  div   bits           poke  kind         chain gap
    vecs[0] = '{8'hAA, 3'd4,  434, 10'b1101010100,   -1, POKE_NONE,   1'b0,   10};
    vecs[1] = '{8'h55, 3'd4,  434, 10'b1010101010,   -1, POKE_NONE,   1'b0, 5000};
    vecs[2] = '{8'h0F, 3'd0, 5208, 10'b1000011110, 2000, POKE_CHANGE, 1'b0,   10};
    vecs[3] = '{8'h3C, 3'd4,  434, 10'b1001111000, 1000, POKE_SEND,   1'b1,   10};
    vecs[4] = '{8'hC3, 3'd3,  868, 10'b1110000110,   -1, POKE_NONE,   1'b0,    0};
    vecs[5] = '{8'h81, 3'd4,  434, 10'b1100000010,   -1, POKE_NONE,   1'b0,   10};

    // Reset held for 20 clocks: outputs at their reset values throughout
    begin
      int bad;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
        step();
        if (Rs232_Tx !== 1'b1 || Tx_Done !== 1'b0 || uart_state !== 1'b0) bad++;
      end
      chk("reset_hold", 32'(bad), 32'd0);
      chk("reset_line", 32'(Rs232_Tx), 32'd1);
    end
    Rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      run_frame(i, (i > 0) && vecs[i-1].chain);
    end

    // Asynchronous reset mid-frame aborts with no Tx_Done
    idle_check("abort_pre_idle", 10);
    data_byte = 8'hA5;
    baud_set  = 3'd4;
    send_en   = 1'b1;
    step();
    send_en   = 1'b0;
    repeat (1000) step();
    chk("abort_busy_before", 32'(uart_state), 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("abort_line_async", 32'(Rs232_Tx), 32'd1);
    chk("abort_state_async", 32'(uart_state), 32'd0);
    chk("abort_no_done", 32'(Tx_Done), 32'd0);
    step();
    step();
    Rst_n = 1'b1;
    idle_check("abort_post_idle", 5000);

    // Fresh frame after the abort
    run_frame(5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_byte_tx_core
`default_nettype wire
